datamemory_store_buffer: RTL and testbench
==========================================

// Module: datamemory_store_buffer
// PURPOSE
//  Write-side companion to the asynchronous-read data memory: accepts CPU store
//  requests (SB/SH/SW) over a valid/ready handshake and queues them in a small FIFO.
//  It drains one entry per cycle onto the memory write port as word index,
//  lane-replicated data and byte enables.
//  It reports pending-store address hits so the load path can stall.
// PARAMETERS
//  ADDRESS_WIDTH  5   word-index width of the data memory (2**ADDRESS_WIDTH words)
//  DATA_WIDTH     32  data width; only 32 is supported (4 byte lanes)
//  DEPTH          4   store FIFO entries; power of two, >= 2
// PORTS
//  clk        in   1              rising-edge clock
//  rst_n      in   1              synchronous active-low reset
//  st_valid   in   1              store request valid
//  st_ready   out  1              buffer can accept a request (= !full)
//  st_addr    in   DATA_WIDTH     byte address of store
//  st_data    in   DATA_WIDTH     store data, right-aligned (rs2)
//  st_size    in   2              00=byte, 01=half, 10=word, 11=illegal
//  st_err     out  1              one-cycle pulse: last accepted request was misaligned/illegal
//  mem_stall  in   1              memory cannot take a write this cycle
//  mem_we     out  1              write strobe to memory
//  mem_addr   out  ADDRESS_WIDTH  word index = head.addr[ADDRESS_WIDTH+1:2]
//  mem_wd     out  DATA_WIDTH     lane-replicated write data
//  mem_be     out  4              byte enables, bit i = byte lane i
//  ld_addr    in   DATA_WIDTH     byte address of the load in flight
//  fwd_hit    out  1              a valid entry matches ld_addr's word index
//  empty      out  1              FIFO holds no entries
// BEHAVIOUR
//  Reset (rst_n low at a clk edge):
//   - wr_ptr, rd_ptr and count cleared; st_err=0.
//   - Queued stores are discarded, including in-flight ones; no partial write follows.
//   - After reset, outputs read: st_ready=1, mem_we=0, fwd_hit=0, empty=1.
//  Accept: on an edge with st_valid && st_ready.
//   - Lane formatting (lanes from addr[1:0]):
//     - byte: be = 1<<addr[1:0]; wd = {4{data[7:0]}}.
//     - half: be = addr[1] ? 4'b1100 : 4'b0011; wd = {2{data[15:0]}}.
//     - word: be = 4'b1111; wd = data.
//   - Misaligned is half with addr[0]=1, or word with addr[1:0]!=0. Misaligned or size
//     11 is accepted but NOT enqueued: st_err=1 for exactly the next cycle, FIFO unchanged.
//  Drain: head entry drives mem_addr/mem_wd/mem_be combinationally.
//   - mem_we = !empty && !mem_stall.
//   - On each edge with mem_we=1 the head is popped; the memory captures on that same edge.
//   - Latency: accepted at edge N into an empty FIFO -> mem_we high in cycle N+1 -> written
//     at edge N+1. Throughput 1 store/cycle.
//   - mem_stall=1 freezes the head; mem_* stay stable, mem_we=0.
//  Full/empty:
//   - count ranges 0..DEPTH; st_ready = (count != DEPTH). No full-bypass: a full FIFO
//     refuses a push even if a pop occurs in the same cycle.
//   - Simultaneous push and pop: count unchanged, both pointers advance.
//   - Pointers wrap modulo DEPTH.
//   - empty = (count == 0); mem_* data don't-care when empty, but mem_we must be 0.
//  Forwarding check (combinational):
//   - fwd_hit = OR over valid entries of (entry.word_idx == ld_addr[ADDRESS_WIDTH+1:2]).
//   - The head being written this cycle still counts as a hit.
//   - A request being accepted this cycle does not count as a hit.
//   - Upper address bits above ADDRESS_WIDTH+1 are ignored.
//  Order: entries drain strictly FIFO; same-word stores are never merged or reordered.
// TESTING
//  1. Reset release, idle -> st_ready=1, empty=1, mem_we=0, fwd_hit=0.
//  2. SW addr=0x0000_0008 data=0xDEADBEEF:
//     -> next cycle mem_we=1, mem_addr=2, mem_be=1111, mem_wd=0xDEADBEEF; empty=1 after the edge.
//  3. SB addr=0x0000_0007 data=0x000000A5 -> mem_addr=1, mem_be=1000, mem_wd=0xA5A5A5A5.
//     SH addr=0x0000_0006 data=0x1234 -> mem_be=1100, mem_wd=0x12341234.
//  4. Hold mem_stall=1 and push 5 SWs: 4 accepted, then st_ready=0 and the 5th is held.
//     Release stall -> 4 writes on consecutive cycles, in order; then the 5th is accepted.
//  5. SH addr=0x0000_0003 -> accepted with no FIFO change; st_err=1 for one cycle; no mem_we.
//     size=11 gives the same response.
//  6. Queue SW addr=0x10 with mem_stall=1; ld_addr=0x13 -> fwd_hit=1, ld_addr=0x14 -> fwd_hit=0.
//     Then pulse rst_n low for one edge -> empty=1, fwd_hit=0, the write never occurs.

Source files
------------

// File: rtl/datamemory_store_buffer.sv
// Store buffer in front of the data memory write port: formats SB/SH/SW into
// byte lanes, queues them in a small FIFO and drains one per cycle.
module datamemory_store_buffer #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int DEPTH         = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     st_valid,
   output logic                     st_ready,
   input  logic [DATA_WIDTH-1:0]    st_addr,
   input  logic [DATA_WIDTH-1:0]    st_data,
   input  logic [1:0]               st_size,
   output logic                     st_err,
   input  logic                     mem_stall,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wd,
   output logic [3:0]               mem_be,
   input  logic [DATA_WIDTH-1:0]    ld_addr,
   output logic                     fwd_hit,
   output logic                     empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [ADDRESS_WIDTH-1:0] widx_q [DEPTH];
   logic [DATA_WIDTH-1:0]    wd_q   [DEPTH];
   logic [3:0]               be_q   [DEPTH];
   logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
   logic [PW:0]              count_q;
   logic                     st_err_q;

   logic [3:0]            fmt_be;
   logic [DATA_WIDTH-1:0] fmt_wd;
   logic                  bad, accept, push, pop;

   // Address bits above the memory's word index carry no meaning here.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{st_addr[DATA_WIDTH-1:ADDRESS_WIDTH+2],
                               ld_addr[DATA_WIDTH-1:ADDRESS_WIDTH+2], ld_addr[1:0]};

   assign empty    = (count_q == '0);
   assign st_ready = (count_q != (PW+1)'(DEPTH));
   assign st_err   = st_err_q;
   assign mem_we   = !empty && !mem_stall;
   assign mem_addr = widx_q[rd_ptr_q];
   assign mem_wd   = wd_q[rd_ptr_q];
   assign mem_be   = be_q[rd_ptr_q];

   always_comb begin
      fmt_be = 4'b0000;
      fmt_wd = st_data;
      bad    = 1'b0;
      case (st_size)
         2'b00: begin
            fmt_be = 4'b0001 << st_addr[1:0];
            fmt_wd = {4{st_data[7:0]}};
         end
         2'b01: begin
            bad    = st_addr[0];
            fmt_be = st_addr[1] ? 4'b1100 : 4'b0011;
            fmt_wd = {2{st_data[15:0]}};
         end
         2'b10: begin
            bad    = |st_addr[1:0];
            fmt_be = 4'b1111;
         end
         default: bad = 1'b1;
      endcase
   end

   // Faulty requests complete the handshake but never reach the FIFO.
   assign accept = st_valid && st_ready;
   assign push   = accept && !bad;
   assign pop    = mem_we;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         st_err_q <= 1'b0;
      end else begin
         st_err_q <= accept && bad;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         widx_q[wr_ptr_q] <= st_addr[ADDRESS_WIDTH+1:2];
         wd_q[wr_ptr_q]   <= fmt_wd;
         be_q[wr_ptr_q]   <= fmt_be;
      end
   end

   // An entry is live when its distance from the head is below count.
   always_comb begin
      logic [PW-1:0] off;
      fwd_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         off = PW'(i) - rd_ptr_q;
         if (({1'b0, off} < count_q) && (widx_q[i] == ld_addr[ADDRESS_WIDTH+1:2]))
            fwd_hit = 1'b1;
      end
   end
endmodule

// File: tb/tb_datamemory_store_buffer.sv
// Self-checking bench: queue-based reference model compared every cycle,
// plus directed literal checks and a randomized phase.
module tb_datamemory_store_buffer;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n, st_valid, st_ready, st_err, mem_stall, mem_we, fwd_hit, empty;
   logic [DW-1:0] st_addr, st_data, mem_wd, ld_addr;
   logic [1:0]    st_size;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_be;

   datamemory_store_buffer #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
      .st_addr(st_addr), .st_data(st_data), .st_size(st_size), .st_err(st_err),
      .mem_stall(mem_stall), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
      .mem_be(mem_be), .ld_addr(ld_addr), .fwd_hit(fwd_hit), .empty(empty)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [AW-1:0] widx;
      logic [31:0]   wd;
      logic [3:0]    be;
   } ent_t;

   ent_t mq[$];
   logic m_err = 1'b0;

   // Reference model: a plain queue updated from the inputs seen at each edge.
   always @(posedge clk) begin
      if (!rst_n) begin
         mq.delete();
         m_err = 1'b0;
      end else begin
         bit acc, pop;
         int nb;
         ent_t e;
         pop = (mq.size() != 0) && !mem_stall;
         acc = st_valid && (mq.size() != DEPTH);
         if (pop) void'(mq.pop_front());
         m_err = 1'b0;
         if (acc) begin
            nb = 1 << st_size;
            if (st_size == 2'b11 || (st_addr % nb) != 0) m_err = 1'b1;
            else begin
               e.widx = st_addr[AW+1:2];
               e.be   = 4'(((1 << nb) - 1) << st_addr[1:0]);
               for (int k = 0; k < 4; k++) e.wd[8*k +: 8] = st_data[8*(k % nb) +: 8];
               mq.push_back(e);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         bit hit;
         hit = 1'b0;
         foreach (mq[i]) if (mq[i].widx == ld_addr[AW+1:2]) hit = 1'b1;
         chk("m_st_ready", st_ready, mq.size() != DEPTH);
         chk("m_empty", empty, mq.size() == 0);
         chk("m_mem_we", mem_we, (mq.size() != 0) && !mem_stall);
         chk("m_st_err", st_err, m_err);
         chk("m_fwd_hit", fwd_hit, hit);
         if (mq.size() != 0) begin
            chk("m_mem_addr", mem_addr, mq[0].widx);
            chk("m_mem_wd", mem_wd, mq[0].wd);
            chk("m_mem_be", mem_be, mq[0].be);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      st_valid = 1'b1; st_addr = a; st_data = d; st_size = s;
   endtask

   initial begin
      int acc;
      rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = 2'b10;
      mem_stall = 1'b0; ld_addr = 32'hFFFF_FFFC;
      tick(); tick();
      chk_en = 1'b1;
      rst_n = 1'b1;

      // idle after reset
      @(negedge clk);
      chk("rst_ready", st_ready, 1); chk("rst_empty", empty, 1);
      chk("rst_we", mem_we, 0);      chk("rst_fwd", fwd_hit, 0);
      tick();

      // SW 0x8
      req(32'h8, 32'hDEADBEEF, 2'b10);
      tick(); st_valid = 1'b0;
      @(negedge clk);
      chk("sw_we", mem_we, 1); chk("sw_addr", mem_addr, 2);
      chk("sw_be", mem_be, 4'b1111); chk("sw_wd", mem_wd, 32'hDEADBEEF);
      tick();
      @(negedge clk); chk("sw_empty", empty, 1);
      tick();

      // SB 0x7, SH 0x6
      req(32'h7, 32'h000000A5, 2'b00);
      tick(); st_valid = 1'b0;
      @(negedge clk);
      chk("sb_addr", mem_addr, 1); chk("sb_be", mem_be, 4'b1000); chk("sb_wd", mem_wd, 32'hA5A5A5A5);
      tick();
      req(32'h6, 32'h00001234, 2'b01);
      tick(); st_valid = 1'b0;
      @(negedge clk);
      chk("sh_be", mem_be, 4'b1100); chk("sh_wd", mem_wd, 32'h12341234);
      tick();

      // fill under stall, 5th request held
      mem_stall = 1'b1; acc = 0;
      req(32'h20, $urandom(), 2'b10);
      repeat (6) begin
         bit took;
         @(negedge clk);
         took = st_ready && st_valid;
         tick();
         if (took) begin
            acc++;
            req(32'h20 + 32'(4 * acc), $urandom(), 2'b10);
         end
      end
      chk("full_accepts", acc, 4);
      @(negedge clk); chk("full_ready", st_ready, 0); chk("full_we", mem_we, 0);
      tick();
      mem_stall = 1'b0;
      for (int k = 0; k < 5; k++) begin
         bit took;
         @(negedge clk);
         chk("drain_we", mem_we, 1);
         chk("drain_addr", mem_addr, 8 + k);
         took = st_ready && st_valid;
         tick();
         if (took) st_valid = 1'b0;
      end
      @(negedge clk); chk("drain_empty", empty, 1);
      tick();

      // misaligned / illegal
      req(32'h3, 32'h0000BEEF, 2'b01);
      tick(); st_valid = 1'b0;
      @(negedge clk); chk("mis_err", st_err, 1); chk("mis_we", mem_we, 0); chk("mis_empty", empty, 1);
      tick();
      @(negedge clk); chk("mis_err_clr", st_err, 0);
      req(32'h0, 32'h1, 2'b11);
      tick(); st_valid = 1'b0;
      @(negedge clk); chk("ill_err", st_err, 1); chk("ill_we", mem_we, 0);
      tick();

      // forwarding hit then reset discards entry
      mem_stall = 1'b1;
      req(32'h10, 32'h55AA55AA, 2'b10);
      tick(); st_valid = 1'b0; ld_addr = 32'h13;
      @(negedge clk); chk("fwd_13", fwd_hit, 1);
      tick(); ld_addr = 32'h14;
      @(negedge clk); chk("fwd_14", fwd_hit, 0);
      tick(); ld_addr = 32'hFFFF_FF90;
      @(negedge clk); chk("fwd_hi_bits", fwd_hit, 1);
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; mem_stall = 1'b0;
      @(negedge clk);
      chk("rst2_empty", empty, 1); chk("rst2_fwd", fwd_hit, 0); chk("rst2_we", mem_we, 0);
      tick();

      // random phase
      repeat (600) begin
         int s;
         s = $urandom_range(0, 7);
         st_valid  = ($urandom_range(0, 3) != 0);
         st_size   = (s > 3) ? 2'b10 : 2'(s);
         st_addr   = ($urandom() & 32'hFFFF_FF80) | 32'($urandom_range(0, 15));
         st_data   = $urandom();
         mem_stall = ($urandom_range(0, 9) < 4);
         ld_addr   = ($urandom() & 32'hFFFF_FF80) | 32'($urandom_range(0, 15));
         rst_n     = ($urandom_range(0, 99) != 0);
         tick();
      end
      rst_n = 1'b1; st_valid = 1'b0;
      tick(); tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
